// File: rtl/scan_mux_tdm_if.sv
// Output stream of scan_mux_tdm: selected word, its channel index and a valid/ready handshake.
interface scan_mux_tdm_if #(
    parameter int WIDTH = 4,
    parameter int SELW  = 4
);
    logic [WIDTH-1:0] dout;
    logic [SELW-1:0]  dout_ch;
    logic             dout_valid;
    logic             dout_ready;

    modport master (output dout, dout_ch, dout_valid, input dout_ready);
    modport slave  (input dout, dout_ch, dout_valid, output dout_ready);
endinterface

// File: rtl/scan_mux_tdm.sv
// Registered NCH:1 mux with single-pick and dwell-paced auto-scan modes,
// presenting each captured word on a valid/ready stream.
module scan_mux_tdm #(
    parameter int WIDTH  = 4,
    parameter int NCH    = 16,
    parameter int DWELLW = 8,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic [SELW-1:0]      sel_in,
    input  logic                 mode,
    input  logic [DWELLW-1:0]    dwell,
    input  logic                 start,
    input  logic                 stop,
    output logic                 busy,
    output logic                 scan_done,
    output logic                 sel_err,
    scan_mux_tdm_if.master       dout_if
);

    typedef enum logic [1:0] {IDLE, DWELL, SAMPLE, PRESENT} state_t;

    localparam logic [SELW:0]     NCH_W     = (SELW+1)'(NCH);
    localparam logic [SELW-1:0]   CH_LAST   = SELW'(NCH-1);
    localparam logic [SELW-1:0]   CH_ONE    = SELW'(1);
    localparam logic [DWELLW-1:0] DWELL_ONE = DWELLW'(1);

    state_t                    state, state_nxt;
    logic [SELW-1:0]           ch;
    logic [DWELLW-1:0]         dwell_cnt, dwell_r;
    logic                      mode_r;
    logic [NCH-1:0][WIDTH-1:0] din_w;
    logic                      ch_ok, ch_last, xfer;

    assign din_w   = din;
    assign ch_ok   = {1'b0, ch} < NCH_W;
    assign ch_last = (ch == CH_LAST);
    assign xfer    = dout_if.dout_valid & dout_if.dout_ready;
    assign busy    = (state != IDLE);
    assign sel_err = (state == SAMPLE) && !mode_r && !ch_ok;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (!mode || dwell == '0) ? SAMPLE : DWELL;
            DWELL:   if (dwell_cnt <= DWELL_ONE) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = PRESENT;
            PRESENT: if (xfer) begin
                if (!mode_r || ch_last) state_nxt = IDLE;
                else                    state_nxt = (dwell_r == '0) ? SAMPLE : DWELL;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort wins over everything, including a start in IDLE.
        if (stop) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            ch                 <= '0;
            dwell_cnt          <= '0;
            dwell_r            <= '0;
            mode_r             <= 1'b0;
            scan_done          <= 1'b0;
            dout_if.dout       <= '0;
            dout_if.dout_ch    <= '0;
            dout_if.dout_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            scan_done <= 1'b0;
            case (state)
                IDLE: if (start && !stop) begin
                    mode_r    <= mode;
                    dwell_r   <= dwell;
                    dwell_cnt <= dwell;
                    ch        <= mode ? '0 : sel_in;
                end
                DWELL: dwell_cnt <= dwell_cnt - DWELL_ONE;
                SAMPLE: begin
                    // Out-of-range picks still complete a transfer, carrying zero data.
                    dout_if.dout       <= ch_ok ? din_w[ch] : '0;
                    dout_if.dout_ch    <= ch;
                    dout_if.dout_valid <= 1'b1;
                end
                PRESENT: if (xfer) begin
                    dout_if.dout_valid <= 1'b0;
                    dwell_cnt          <= dwell_r;
                    if (mode_r) begin
                        if (ch_last) begin
                            ch        <= '0;
                            scan_done <= !stop;
                        end else begin
                            ch <= ch + CH_ONE;
                        end
                    end
                end
                default: ;
            endcase
            if (stop) dout_if.dout_valid <= 1'b0;
        end
    end

endmodule
